// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   hz_state_e : MDU busy FSM encoding (ST_RUN, ST_MD_BUSY)
//   REG_ZERO   : architectural zero register, never a hazard source
//   reg_match  : true when a producer register feeds a source of the ID instruction
package hazard_ctrl_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic logic reg_match(input logic [4:0] r,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       uses_rt);
    return (r != REG_ZERO) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
//   clk, reset : clock and synchronous active-high reset (clears count)
//   inc        : add one this cycle unless already at all-ones
//   count      : current value, holds at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller placed beside the ID stage.
// Detects load-use, branch-operand and mult/div-busy hazards and drives the
// PC / IF/ID enables and the IF/ID / ID/EX flushes combinationally. The only
// state is the MDU busy FSM with its down-counter and two perf counters.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   idRs, idRt, idUsesRt  : sources of the instruction in ID
//   idBranch, idReadsHiLo, idMdStart : ID instruction class
//   exMemRead, exRegWrite, exRd      : producer in EX
//   memMemRead, memRd                : load in MEM
//   branchTaken           : branch/jump in ID resolved taken
//   hzdWrite, ifidWrite   : PC and IF/ID enables (0 = hold)
//   ifidFlush, idexFlush  : squash IF/ID, bubble into ID/EX
//   mdBusy                : MDU busy (registered)
//   stallCount, flushCount: saturating perf counters
//   dbgState              : current MDU FSM state
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       idRs,
  input  logic [4:0]       idRt,
  input  logic             idUsesRt,
  input  logic             idBranch,
  input  logic             idReadsHiLo,
  input  logic             idMdStart,
  input  logic             exMemRead,
  input  logic             exRegWrite,
  input  logic [4:0]       exRd,
  input  logic             memMemRead,
  input  logic [4:0]       memRd,
  input  logic             branchTaken,
  output logic             hzdWrite,
  output logic             ifidWrite,
  output logic             ifidFlush,
  output logic             idexFlush,
  output logic             mdBusy,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount,
  output hz_state_e        dbgState
);

  localparam int MDC_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
  localparam logic [MDC_W-1:0] MDC_LOAD = MDC_W'(MD_LATENCY - 1);

  hz_state_e        state, state_d;
  logic [MDC_W-1:0] mdCnt, mdCnt_d;

  logic loadUse, brEx, brMem, mdHaz, stall;

  assign mdBusy   = (state == ST_MD_BUSY);
  assign dbgState = state;

  assign loadUse = exMemRead && reg_match(exRd, idRs, idRt, idUsesRt);
  // ALU result is forwarded to EX consumers but not to the ID comparator.
  assign brEx    = idBranch && exRegWrite && !exMemRead
                   && reg_match(exRd, idRs, idRt, idUsesRt);
  assign brMem   = idBranch && memMemRead && reg_match(memRd, idRs, idRt, idUsesRt);
  assign mdHaz   = mdBusy && (idReadsHiLo || idMdStart);
  assign stall   = loadUse | brEx | brMem | mdHaz;

  // Reset overrides everything so outputs are clean even with X inputs;
  // a stall masks a taken branch because its operands are not yet valid.
  assign hzdWrite  = reset | ~stall;
  assign ifidWrite = reset | ~stall;
  assign idexFlush = ~reset & stall;
  assign ifidFlush = ~reset & ~stall & branchTaken;

  always_comb begin
    state_d = state;
    mdCnt_d = mdCnt;
    case (state)
      ST_RUN: begin
        // The mult/div only starts once it actually leaves ID.
        if (idMdStart && !stall) begin
          state_d = ST_MD_BUSY;
          mdCnt_d = MDC_LOAD;
        end
      end
      ST_MD_BUSY: begin
        if (mdCnt == '0) begin
          state_d = ST_RUN;
        end else begin
          mdCnt_d = mdCnt - 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
        mdCnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      mdCnt <= '0;
    end else begin
      state <= state_d;
      mdCnt <= mdCnt_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~hzdWrite),
    .count (stallCount)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ifidFlush),
    .count (flushCount)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int MD_LATENCY = 4;
  localparam int CNT_W      = 4;

  logic             clk;
  logic             reset;
  logic [4:0]       idRs, idRt, exRd, memRd;
  logic             idUsesRt, idBranch, idReadsHiLo, idMdStart;
  logic             exMemRead, exRegWrite, memMemRead, branchTaken;
  logic             hzdWrite, ifidWrite, ifidFlush, idexFlush, mdBusy;
  logic [CNT_W-1:0] stallCount, flushCount;
  hz_state_e        dbgState;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.MD_LATENCY(MD_LATENCY), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt), .idBranch(idBranch),
    .idReadsHiLo(idReadsHiLo), .idMdStart(idMdStart),
    .exMemRead(exMemRead), .exRegWrite(exRegWrite), .exRd(exRd),
    .memMemRead(memMemRead), .memRd(memRd), .branchTaken(branchTaken),
    .hzdWrite(hzdWrite), .ifidWrite(ifidWrite), .ifidFlush(ifidFlush),
    .idexFlush(idexFlush), .mdBusy(mdBusy),
    .stallCount(stallCount), .flushCount(flushCount), .dbgState(dbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic clear_inputs();
    idRs = 5'd0; idRt = 5'd0; idUsesRt = 1'b0; idBranch = 1'b0;
    idReadsHiLo = 1'b0; idMdStart = 1'b0;
    exMemRead = 1'b0; exRegWrite = 1'b0; exRd = 5'd0;
    memMemRead = 1'b0; memRd = 5'd0; branchTaken = 1'b0;
  endtask

  // inputs change on the falling edge, outputs are sampled 1ns later
  task automatic next_cycle();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_stall(input string tag, input logic exp_stall);
    check({tag, "_hzdWrite"},  32'(hzdWrite),  32'(!exp_stall));
    check({tag, "_ifidWrite"}, 32'(ifidWrite), 32'(!exp_stall));
    check({tag, "_idexFlush"}, 32'(idexFlush), 32'(exp_stall));
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    // a load-use pattern while reset is high must not stall
    exMemRead = 1'b1; exRd = 5'd8; idRs = 5'd8; branchTaken = 1'b1;
    @(posedge clk);
    @(negedge clk);
    settle();
    check_stall("reset_outputs", 1'b0);
    check("reset_ifidFlush", 32'(ifidFlush), 32'd0);
    check("reset_stallCount", 32'(stallCount), 32'd0);
    check("reset_flushCount", 32'(flushCount), 32'd0);
    check("reset_mdBusy", 32'(mdBusy), 32'd0);
    check("reset_state", 32'(dbgState), 32'(ST_RUN));

    // load-use on rs
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    exMemRead = 1'b1; exRd = 5'd8; idRs = 5'd8;
    settle();
    check_stall("loaduse", 1'b1);
    check("loaduse_ifidFlush", 32'(ifidFlush), 32'd0);
    check("loaduse_cnt_before", 32'(stallCount), 32'd0);
    next_cycle(); settle();
    check_stall("after_loaduse", 1'b0);
    check("loaduse_cnt_after", 32'(stallCount), 32'd1);

    // register zero never hazards
    next_cycle();
    exMemRead = 1'b1; exRd = 5'd0; idRs = 5'd0; idRt = 5'd0; idUsesRt = 1'b1;
    settle();
    check_stall("reg_zero", 1'b0);

    // rt only matters when the ID instruction reads it
    next_cycle();
    exMemRead = 1'b1; exRd = 5'd5; idRs = 5'd3; idRt = 5'd5; idUsesRt = 1'b0;
    settle();
    check_stall("rt_unused", 1'b0);
    next_cycle();
    exMemRead = 1'b1; exRd = 5'd5; idRs = 5'd3; idRt = 5'd5; idUsesRt = 1'b1;
    settle();
    check_stall("rt_used", 1'b1);
    next_cycle(); settle();
    check("rt_cnt", 32'(stallCount), 32'd2);

    // branch-on-load: beq $9 with lw $9 in EX, taken flag held high
    next_cycle();
    idBranch = 1'b1; idRs = 5'd9; branchTaken = 1'b1;
    exMemRead = 1'b1; exRegWrite = 1'b1; exRd = 5'd9;
    settle();
    check_stall("brload_c1", 1'b1);
    check("brload_c1_ifidFlush", 32'(ifidFlush), 32'd0);
    next_cycle();
    idBranch = 1'b1; idRs = 5'd9; branchTaken = 1'b1;
    memMemRead = 1'b1; memRd = 5'd9;
    settle();
    check_stall("brload_c2", 1'b1);
    check("brload_c2_ifidFlush", 32'(ifidFlush), 32'd0);
    next_cycle();
    idBranch = 1'b1; idRs = 5'd9; branchTaken = 1'b1;
    settle();
    check_stall("brload_c3", 1'b0);
    check("brload_c3_ifidFlush", 32'(ifidFlush), 32'd1);
    next_cycle(); settle();
    check("brload_stallCount", 32'(stallCount), 32'd4);
    check("brload_flushCount", 32'(flushCount), 32'd1);
    check("idle_ifidFlush", 32'(ifidFlush), 32'd0);

    // branch on ALU result: one stall; non-branch consumer does not stall
    next_cycle();
    idBranch = 1'b1; idRs = 5'd4; exRegWrite = 1'b1; exRd = 5'd4;
    settle();
    check_stall("brex", 1'b1);
    next_cycle();
    idBranch = 1'b0; idRs = 5'd4; exRegWrite = 1'b1; exRd = 5'd4;
    settle();
    check_stall("alu_fwd", 1'b0);
    next_cycle(); settle();
    check("brex_stallCount", 32'(stallCount), 32'd5);

    // MDU: div leaves ID at t0, mflo in ID from t1
    next_cycle();
    idMdStart = 1'b1;
    settle();
    check_stall("md_t0", 1'b0);
    check("md_t0_busy", 32'(mdBusy), 32'd0);
    for (int t = 1; t <= 4; t++) begin
      next_cycle();
      idReadsHiLo = 1'b1;
      settle();
      check($sformatf("md_t%0d_busy", t), 32'(mdBusy), 32'd1);
      check_stall($sformatf("md_t%0d", t), 1'b1);
    end
    next_cycle();
    idReadsHiLo = 1'b1;
    settle();
    check("md_t5_busy", 32'(mdBusy), 32'd0);
    check("md_t5_state", 32'(dbgState), 32'(ST_RUN));
    check_stall("md_t5", 1'b0);
    check("md_stallCount", 32'(stallCount), 32'd9);

    // saturation: ten more stall cycles push 9 to all-ones and hold there
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      exMemRead = 1'b1; exRd = 5'd7; idRs = 5'd7;
    end
    next_cycle(); settle();
    check("sat_stallCount", 32'(stallCount), 32'd15);
    next_cycle();
    exMemRead = 1'b1; exRd = 5'd7; idRs = 5'd7;
    next_cycle(); settle();
    check("sat_hold", 32'(stallCount), 32'd15);

    // reset in the second MD_BUSY cycle abandons the operation
    next_cycle();
    idMdStart = 1'b1;
    next_cycle();
    idReadsHiLo = 1'b1;
    settle();
    check("rst_busy_c1", 32'(mdBusy), 32'd1);
    next_cycle();
    idReadsHiLo = 1'b1;
    reset = 1'b1;
    settle();
    check("rst_busy_c2", 32'(mdBusy), 32'd1);
    check_stall("rst_busy_during", 1'b0);
    next_cycle();
    reset = 1'b0;
    idReadsHiLo = 1'b1;
    settle();
    check("rst_busy_mdBusy", 32'(mdBusy), 32'd0);
    check("rst_busy_stallCount", 32'(stallCount), 32'd0);
    check("rst_busy_flushCount", 32'(flushCount), 32'd0);
    check_stall("rst_busy_mflo", 1'b0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #20000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
